// File: rtl/aqed_pkg.sv
// rtl/aqed_pkg.sv - shared types and defaults for the A-QED stream checker
package aqed_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_IDX_WIDTH  = 16;
  localparam int DEFAULT_RB_CYCLES  = 32;
  localparam int DEFAULT_FIFO_MODE  = 1;

  typedef enum logic [1:0] {
    S_ORIG = 2'd0,
    S_DUP  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } aqed_state_t;

  // Capture record at default sizing; the checker keeps the same layout resized per instance
  typedef struct packed {
    logic [DEFAULT_IDX_WIDTH-1:0]  idx;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          valid;
  } aqed_cap_t;

endpackage

// File: rtl/aqed_stream_checker_if.sv
// rtl/aqed_stream_checker_if.sv - snooped accelerator input/output handshakes
interface aqed_stream_checker_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  exec_dup;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // Environment side: drives the handshakes and the free select
  modport master (
    output in_data, in_valid, in_ready, exec_dup,
    output out_data, out_valid, out_ready
  );

  // Checker side: observes everything, drives nothing
  modport slave (
    input in_data, in_valid, in_ready, exec_dup,
    input out_data, out_valid, out_ready
  );
endinterface

// File: rtl/aqed_rb_monitor.sv
// rtl/aqed_rb_monitor.sv - response-bound watchdog on outstanding data
module aqed_rb_monitor
  import aqed_pkg::*;
#(
  parameter int RB_CYCLES = DEFAULT_RB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in_flight_nz,
  input  logic out_acc,
  output logic rb_fail
);

  localparam int CW = $clog2(RB_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(RB_CYCLES);
  localparam logic [CW-1:0] ONE   = 1;

  logic [CW-1:0] r_rb_cnt;
  logic [CW-1:0] w_rb_cnt_nxt;

  // Count stalled cycles with work outstanding; any accepted output or an empty pipe restarts it
  always_comb begin
    w_rb_cnt_nxt = r_rb_cnt;
    if (!in_flight_nz || out_acc) begin
      w_rb_cnt_nxt = '0;
    end else if (r_rb_cnt != LIMIT) begin
      w_rb_cnt_nxt = r_rb_cnt + ONE;
    end
  end

  // Counter register and sticky failure flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rb_cnt <= '0;
      rb_fail  <= 1'b0;
    end else begin
      r_rb_cnt <= w_rb_cnt_nxt;
      if (w_rb_cnt_nxt == LIMIT) begin
        rb_fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aqed_stream_checker.sv
// rtl/aqed_stream_checker.sv - A-QED self-consistency checker for streaming accelerators
module aqed_stream_checker
  import aqed_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH,
  parameter int RB_CYCLES  = DEFAULT_RB_CYCLES,
  parameter int FIFO_MODE  = DEFAULT_FIFO_MODE
) (
  input  logic                 clk,
  input  logic                 reset,
  aqed_stream_checker_if.slave bus,
  output logic                 qed_done,
  output logic                 qed_check,
  output logic                 rb_fail,
  output logic                 order_fail,
  output logic [IDX_WIDTH-1:0] in_flight
);

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = 1;

  // Same layout as aqed_cap_t, sized for this instance
  typedef struct packed {
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } cap_t;

  logic                  w_in_acc;
  logic                  w_out_acc;
  logic                  w_underflow;
  logic                  w_out_take;
  logic                  w_sat;
  logic [IDX_WIDTH-1:0]  r_in_cnt;
  logic [IDX_WIDTH-1:0]  r_out_cnt;
  logic [IDX_WIDTH-1:0]  w_in_cnt_nxt;
  logic [IDX_WIDTH-1:0]  w_out_cnt_nxt;

  aqed_state_t           r_state;
  cap_t                  r_orig;
  logic [IDX_WIDTH-1:0]  r_dup_idx;
  logic                  r_dup_v;
  logic [DATA_WIDTH-1:0] r_orig_out;
  logic                  r_orig_out_v;
  logic [DATA_WIDTH-1:0] r_dup_out;
  logic                  r_dup_out_v;

  logic                  w_orig_hit;
  logic                  w_dup_hit;
  logic [DATA_WIDTH-1:0] w_orig_out_nxt;
  logic                  w_orig_out_v_nxt;
  logic [DATA_WIDTH-1:0] w_dup_out_nxt;
  logic                  w_dup_out_v_nxt;

  assign w_in_acc    = bus.in_valid & bus.in_ready;
  assign w_out_acc   = bus.out_valid & bus.out_ready;
  // An output with nothing in flight has no matching input and is not given an index
  assign w_underflow = w_out_acc & (in_flight == '0);
  assign w_out_take  = w_out_acc & ~w_underflow;
  // Once either counter pins at all-ones indices are no longer trustworthy, so the FSM stops
  assign w_sat       = (r_in_cnt == '1) | (r_out_cnt == '1);

  assign w_in_cnt_nxt  = (w_in_acc && (r_in_cnt != '1)) ? r_in_cnt + IDX_ONE : r_in_cnt;
  assign w_out_cnt_nxt = (w_out_take && (r_out_cnt != '1)) ? r_out_cnt + IDX_ONE : r_out_cnt;

  // Output capture; the next values also feed the completion decision so done lands one cycle after the last needed output
  always_comb begin
    w_orig_hit       = w_out_take & r_orig.valid & (r_out_cnt == r_orig.idx) & (r_state != S_ORIG);
    w_dup_hit        = w_out_take & r_dup_v & (r_out_cnt == r_dup_idx) & (r_state != S_ORIG);
    w_orig_out_nxt   = w_orig_hit ? bus.out_data : r_orig_out;
    w_orig_out_v_nxt = r_orig_out_v | w_orig_hit;
    w_dup_out_nxt    = w_dup_hit ? bus.out_data : r_dup_out;
    w_dup_out_v_nxt  = r_dup_out_v | w_dup_hit;
  end

  // Transaction counters, occupancy and sticky ordering/saturation flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      in_flight  <= '0;
      order_fail <= 1'b0;
    end else begin
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      in_flight <= w_in_cnt_nxt - w_out_cnt_nxt;
      if (w_underflow || (w_in_cnt_nxt == '1) || (w_out_cnt_nxt == '1)) begin
        order_fail <= 1'b1;
      end
    end
  end

  // Orig/dup selection FSM with output capture and registered verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ORIG;
      r_orig       <= '0;
      r_dup_idx    <= '0;
      r_dup_v      <= 1'b0;
      r_orig_out   <= '0;
      r_orig_out_v <= 1'b0;
      r_dup_out    <= '0;
      r_dup_out_v  <= 1'b0;
      qed_done     <= 1'b0;
      qed_check    <= 1'b0;
    end else if (!w_sat) begin
      r_orig_out   <= w_orig_out_nxt;
      r_orig_out_v <= w_orig_out_v_nxt;
      r_dup_out    <= w_dup_out_nxt;
      r_dup_out_v  <= w_dup_out_v_nxt;
      case (r_state)
        S_ORIG: begin
          if (w_in_acc && bus.exec_dup) begin
            r_orig.idx   <= r_in_cnt;
            r_orig.data  <= bus.in_data;
            r_orig.valid <= 1'b1;
            r_state      <= S_DUP;
          end
        end
        S_DUP: begin
          if (w_in_acc && bus.exec_dup && (bus.in_data == r_orig.data)) begin
            r_dup_idx <= r_in_cnt;
            r_dup_v   <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_orig_out_v_nxt && w_dup_out_v_nxt) begin
            r_state   <= S_DONE;
            qed_done  <= 1'b1;
            qed_check <= (w_orig_out_nxt == w_dup_out_nxt) &&
                         ((FIFO_MODE == 0) || (w_orig_out_nxt == r_orig.data));
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_ORIG;
        end
      endcase
    end
  end

  aqed_rb_monitor #(
    .RB_CYCLES (RB_CYCLES)
  ) u_rb_monitor (
    .clk          (clk),
    .reset        (reset),
    .in_flight_nz (in_flight != '0),
    .out_acc      (w_out_acc),
    .rb_fail      (rb_fail)
  );

endmodule

// File: tb/tb_aqed_stream_checker.sv
// tb/tb_aqed_stream_checker.sv - directed self-checking bench for aqed_stream_checker
module tb_aqed_stream_checker;
  import aqed_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  aqed_stream_checker_if #(.DATA_WIDTH(16)) bus ();

  logic        f_done, f_check, f_rb, f_order;
  logic [15:0] f_inflight;
  logic        c_done, c_check, c_rb, c_order;
  logic [15:0] c_inflight;
  logic        s_done, s_check, s_rb, s_order;
  logic [1:0]  s_inflight;

  always #5 clk = ~clk;

  aqed_stream_checker #(.DATA_WIDTH(16), .IDX_WIDTH(16), .RB_CYCLES(4), .FIFO_MODE(1)) u_fifo (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .qed_done(f_done), .qed_check(f_check), .rb_fail(f_rb), .order_fail(f_order), .in_flight(f_inflight)
  );

  aqed_stream_checker #(.DATA_WIDTH(16), .IDX_WIDTH(16), .RB_CYCLES(4), .FIFO_MODE(0)) u_cons (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .qed_done(c_done), .qed_check(c_check), .rb_fail(c_rb), .order_fail(c_order), .in_flight(c_inflight)
  );

  aqed_stream_checker #(.DATA_WIDTH(16), .IDX_WIDTH(2), .RB_CYCLES(4), .FIFO_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .qed_done(s_done), .qed_check(s_check), .rb_fail(s_rb), .order_fail(s_order), .in_flight(s_inflight)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.in_valid  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.exec_dup  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.out_data  = 16'h0000;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push_in(input logic [15:0] d, input logic dup);
    bus.in_data  = d;
    bus.exec_dup = dup;
    bus.in_valid = 1'b1;
    bus.in_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_ready = 1'b0;
    bus.exec_dup = 1'b0;
  endtask

  task automatic pop_out(input logic [15:0] d);
    bus.out_data  = d;
    bus.out_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    idle_bus();
    step();
    step();
    reset = 1'b0;
    check("rst_done", 32'(f_done), 32'd0);
    check("rst_check", 32'(f_check), 32'd0);
    check("rst_rb", 32'(f_rb), 32'd0);
    check("rst_order", 32'(f_order), 32'd0);
    check("rst_inflight", 32'(f_inflight), 32'd0);

    // 1: identity FIFO, orig at 0, dup at 2
    do_reset();
    push_in(16'hA5A5, 1'b1);
    push_in(16'h1234, 1'b0);
    push_in(16'hA5A5, 1'b1);
    check("t1_inflight3", 32'(f_inflight), 32'd3);
    pop_out(16'hA5A5);
    pop_out(16'h1234);
    check("t1_done_early", 32'(f_done), 32'd0);
    pop_out(16'hA5A5);
    check("t1_done", 32'(f_done), 32'd1);
    check("t1_check", 32'(f_check), 32'd1);
    check("t1_rb", 32'(f_rb), 32'd0);
    check("t1_order", 32'(f_order), 32'd0);
    check("t1_inflight0", 32'(f_inflight), 32'd0);
    step();
    check("t1_done_hold", 32'(f_done), 32'd1);
    check("t1_check_hold", 32'(f_check), 32'd1);

    // 2: corrupted dup output
    do_reset();
    push_in(16'hA5A5, 1'b1);
    push_in(16'h1234, 1'b0);
    push_in(16'hA5A5, 1'b1);
    pop_out(16'hA5A5);
    pop_out(16'h1234);
    pop_out(16'hA5A4);
    check("t2_done", 32'(f_done), 32'd1);
    check("t2_check", 32'(f_check), 32'd0);
    check("t2_cons_check", 32'(c_check), 32'd0);

    // 3: consistent but wrong outputs: FIFO mode rejects, consistency mode accepts
    do_reset();
    push_in(16'hA5A5, 1'b1);
    push_in(16'hA5A5, 1'b1);
    pop_out(16'h0000);
    pop_out(16'h0000);
    check("t3_fifo_done", 32'(f_done), 32'd1);
    check("t3_fifo_check", 32'(f_check), 32'd0);
    check("t3_cons_done", 32'(c_done), 32'd1);
    check("t3_cons_check", 32'(c_check), 32'd1);

    // 4: response bound of 4 with back-pressured output
    do_reset();
    push_in(16'h0042, 1'b0);
    bus.out_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    check("t4_rb_before", 32'(f_rb), 32'd0);
    step();
    check("t4_rb_fire", 32'(f_rb), 32'd1);
    step();
    check("t4_rb_sticky", 32'(f_rb), 32'd1);
    check("t4_inflight", 32'(f_inflight), 32'd1);
    bus.out_valid = 1'b0;

    // 5: underflow
    do_reset();
    pop_out(16'h0007);
    check("t5_order", 32'(f_order), 32'd1);
    check("t5_inflight0", 32'(f_inflight), 32'd0);
    push_in(16'h0008, 1'b0);
    check("t5_inflight1", 32'(f_inflight), 32'd1);

    // 6: reset while waiting with orig output already captured
    do_reset();
    push_in(16'hA5A5, 1'b1);
    push_in(16'hA5A5, 1'b1);
    pop_out(16'hA5A5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_done", 32'(f_done), 32'd0);
    check("t6_inflight", 32'(f_inflight), 32'd0);
    check("t6_order", 32'(f_order), 32'd0);
    check("t6_state", 32'(u_fifo.r_state), 32'(S_ORIG));
    push_in(16'h1111, 1'b1);
    push_in(16'h1111, 1'b1);
    pop_out(16'h1111);
    check("t6_done_early", 32'(f_done), 32'd0);
    pop_out(16'h1111);
    check("t6_done", 32'(f_done), 32'd1);
    check("t6_check", 32'(f_check), 32'd1);

    // 7: 2-bit counters saturate at the third accepted input
    do_reset();
    push_in(16'h0001, 1'b0);
    push_in(16'h0002, 1'b0);
    check("t7_order_before", 32'(s_order), 32'd0);
    push_in(16'h0003, 1'b0);
    check("t7_order_sat", 32'(s_order), 32'd1);
    check("t7_inflight", 32'(s_inflight), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aqed_stream_checker.md
Name: aqed_stream_checker

Overview:
- Parametrised A-QED self-consistency checker for streaming accelerators, with the memory core in FIFO mode as the primary target.
- Snoops the accelerator input and output handshakes. Non-deterministically selects an original input and a later duplicate input carrying identical data, then checks that their outputs match.
- Beyond the prior checker it adds:
  - optional FIFO identity checking (output equals stored word);
  - response-bound monitoring;
  - ordering/underflow detection;
  - generic width and index sizing.
- Instantiated in formal tops next to the DUT. The properties qed_done |-> qed_check, !rb_fail and !order_fail are asserted at the top.

Parameters:
- DATA_WIDTH, 16, width of input/output data words
- IDX_WIDTH, 16, width of transaction counters and captured indices
- RB_CYCLES, 32, response bound: max cycles with data in flight and no output accepted
- FIFO_MODE, 1, 1 = also require orig output == orig input data; 0 = consistency only

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_data  in  DATA_WIDTH  accelerator input word
- in_valid  in  1  input valid
- in_ready  in  1  accelerator accepts input
- exec_dup  in  1  free (solver-driven) select for orig/dup capture
- out_data  in  DATA_WIDTH  accelerator output word
- out_valid  in  1  output valid
- out_ready  in  1  consumer accepts output
- qed_done  out  1  both orig and dup outputs captured; sticky
- qed_check  out  1  comparison result; meaningful only when qed_done=1
- rb_fail  out  1  response bound violated; sticky
- order_fail  out  1  output accepted with nothing in flight, or counter saturation; sticky
- in_flight  out  IDX_WIDTH  accepted inputs minus accepted outputs

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on posedge clk. While reset=1 every register clears on the next edge. Reset mid-operation abandons any capture.
- Reset values: qed_done=0, qed_check=0, rb_fail=0, order_fail=0, in_flight=0, state=S_ORIG.
- Handshake definitions: in_acc = in_valid & in_ready; out_acc = out_valid & out_ready. Both may occur in the same cycle.
- Counters: in_cnt increments on in_acc; out_cnt increments on out_acc. in_flight = in_cnt - out_cnt, registered, updated the same edge.
- Saturation: counters saturate at all-ones. Reaching saturation sets order_fail and freezes the FSM.
- Underflow: out_acc while in_flight==0 sets order_fail; out_cnt does not increment. There is no same-cycle bypass: an input accepted this cycle is not yet in flight.
- FSM, state S_ORIG: on in_acc & exec_dup, capture orig_idx<=in_cnt and orig_data<=in_data, then go to S_DUP.
- FSM, state S_DUP: on in_acc & exec_dup & (in_data==orig_data), capture dup_idx<=in_cnt, then go to S_WAIT. Non-matching or exec_dup=0 inputs are ignored.
- FSM, state S_WAIT: when orig_out_v & dup_out_v, go to S_DONE.
- FSM, state S_DONE: terminal until reset.
- Output capture runs in every state except S_ORIG:
  - on out_acc with out_cnt==orig_idx and orig_idx valid: orig_out<=out_data, set orig_out_v;
  - on out_acc with out_cnt==dup_idx and dup_idx valid: dup_out<=out_data, set dup_out_v.
  - The orig output may arrive while still in S_DUP.
- Completion: on the S_WAIT->S_DONE edge, qed_done<=1 and qed_check<=(orig_out==dup_out) & (FIFO_MODE==0 | orig_out==orig_data). Both then hold.
- Response-bound monitor:
  - rb_cnt increments each cycle with in_flight>0 and !out_acc;
  - it clears on out_acc or when in_flight==0;
  - rb_fail is set when rb_cnt reaches RB_CYCLES.
  - out_valid=1 with out_ready=0 still counts, so backpressure must be constrained at the top.
- Latency: all flags are registered, appearing one cycle after the causing handshake.

Decomposition:
- Package aqed_pkg holds:
  - state enum aqed_state_t {S_ORIG, S_DUP, S_WAIT, S_DONE};
  - default parameter constants;
  - a capture-record struct (idx, data, valid).
- One sub-module, aqed_rb_monitor. Inputs: clk, reset, in_flight_nz, out_acc. Output: rb_fail. Parameter: RB_CYCLES.

Test Plan:
1. Identity FIFO, inputs 0xA5A5 (exec_dup=1), 0x1234, 0xA5A5 (exec_dup=1), outputs in order -> qed_done=1 one cycle after 3rd output, qed_check=1, no fail flags.
2. Corrupting model returns 0xA5A4 for dup -> qed_done=1, qed_check=0.
3. FIFO_MODE=1, both outputs 0x0000 for inputs 0xA5A5 -> qed_check=0; same stimulus with FIFO_MODE=0 -> qed_check=1.
4. RB_CYCLES=4, one input accepted then out_valid=0 for 4 cycles -> rb_fail=1 on 5th edge, sticky; in_flight=1.
5. out_acc with in_flight=0 -> order_fail=1 next cycle, out_cnt unchanged.
6. Reset asserted in S_WAIT with orig_out_v=1 -> all outputs 0 and state S_ORIG next edge; a fresh sequence then completes normally.
